// File: rtl/bp_cfg_seq_pkg.sv
// Shared constants for the BlackParrot post-reset config sequencer:
// tile config register map and the sequencer state encoding.
package bp_cfg_seq_pkg;

  localparam logic [15:0] FREEZE      = 16'h0002;
  localparam logic [15:0] CORE_ID     = 16'h0004;
  localparam logic [15:0] ICACHE_MODE = 16'h0006;
  localparam logic [15:0] DCACHE_MODE = 16'h0008;
  localparam logic [15:0] CCE_MODE    = 16'h000A;

  localparam logic [2:0]  LAST_REG    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_GAP,
    S_UNFRZ,
    S_READ,
    S_RWAIT,
    S_DONE
  } bp_cfg_seq_state_e;

endpackage

// File: rtl/bp_cfg_seq_gap_timer.sv
// Settle-gap down-counter: load arms it, expired_o marks the last gap cycle.
module bp_cfg_seq_gap_timer #(
  parameter int gap_cycles_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int GW = (gap_cycles_p > 0) ? $clog2(gap_cycles_p + 1) : 1;

  logic [GW-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      cnt <= '0;
    else if (load_i)
      cnt <= GW'(gap_cycles_p);
    else if (en_i && cnt != '0)
      cnt <= cnt - GW'(1);
  end

  assign expired_o = (cnt <= GW'(1));

endmodule

// File: rtl/bp_cfg_seq.sv
// Post-reset tile config sequencer: programs every core tile, then unfreezes each.
// Optional readback-and-compare after each write under BP_CFG_SEQ_READBACK_EN.
//   state | meaning
//   IDLE  | waiting for start_i
//   PROG  | config write of reg_cnt register to core_cnt
//   GAP   | settle cycles after an accepted write
//   UNFRZ | freeze=0 write to core_cnt
//   READ  | readback request of the last write (readback build)
//   RWAIT | waiting for readback data (readback build)
//   DONE  | sequence complete, sticky
module bp_cfg_seq
  import bp_cfg_seq_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int cce_mode_p       = 0,
  parameter int cache_mode_p     = 0,
  parameter int gap_cycles_p     = 4,
  localparam int IW = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [IW-1:0]               cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef BP_CFG_SEQ_READBACK_EN
  ,
  output logic                        cfg_r_v_o,
  input  logic                        cfg_r_ready_i,
  input  logic [cfg_data_width_p-1:0] cfg_r_data_i,
  input  logic                        cfg_r_data_v_i,
  output logic                        error_o
`endif
);

  localparam int CW = $clog2(num_core_p) + 1;
  localparam int AW = cfg_addr_width_p;
  localparam int DW = cfg_data_width_p;

  bp_cfg_seq_state_e state, state_nxt;
  logic [CW-1:0] core_cnt, core_nxt;
  logic [2:0]    reg_cnt, reg_nxt;
  logic          unfrz, unfrz_nxt;
  logic          advance, last_core, gap_load, gap_expired, payload_en;

  assign last_core = (core_cnt == CW'(num_core_p - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= S_IDLE;
      core_cnt <= '0;
      reg_cnt  <= '0;
      unfrz    <= 1'b0;
    end else begin
      state    <= state_nxt;
      core_cnt <= core_nxt;
      reg_cnt  <= reg_nxt;
      unfrz    <= unfrz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    core_nxt  = core_cnt;
    reg_nxt   = reg_cnt;
    unfrz_nxt = unfrz;
    advance   = 1'b0;
    gap_load  = 1'b0;
    case (state)
      S_IDLE: if (start_i) begin
        core_nxt  = '0;
        reg_nxt   = '0;
        unfrz_nxt = 1'b0;
        state_nxt = S_PROG;
      end
      S_PROG, S_UNFRZ: if (cfg_ready_i) begin
`ifdef BP_CFG_SEQ_READBACK_EN
        state_nxt = S_READ;
`else
        advance = 1'b1;
`endif
      end
`ifdef BP_CFG_SEQ_READBACK_EN
      S_READ:  if (cfg_r_ready_i) state_nxt = S_RWAIT;
      S_RWAIT: if (cfg_r_data_v_i) advance = 1'b1;
`endif
      S_GAP: if (gap_expired) state_nxt = unfrz ? S_UNFRZ : S_PROG;
      default: ;
    endcase

    // counters only move once the write (and readback, if built) completes
    if (advance) begin
      if (unfrz) begin
        core_nxt = core_cnt + CW'(1);
      end else if (reg_cnt == LAST_REG) begin
        reg_nxt = '0;
        if (last_core) begin
          core_nxt  = '0;
          unfrz_nxt = 1'b1;
        end else begin
          core_nxt = core_cnt + CW'(1);
        end
      end else begin
        reg_nxt = reg_cnt + 3'd1;
      end

      if (unfrz && last_core) begin
        state_nxt = S_DONE;
      end else if (gap_cycles_p > 0) begin
        state_nxt = S_GAP;
        gap_load  = 1'b1;
      end else begin
        state_nxt = unfrz_nxt ? S_UNFRZ : S_PROG;
      end
    end
  end

  assign payload_en = (state == S_PROG) || (state == S_UNFRZ) ||
                      (state == S_READ) || (state == S_RWAIT);

  always_comb begin
    cfg_v_o       = (state == S_PROG) || (state == S_UNFRZ);
    cfg_core_id_o = '0;
    cfg_addr_o    = '0;
    cfg_data_o    = '0;
    if (payload_en) begin
      cfg_core_id_o = IW'(core_cnt);
      if (unfrz) begin
        cfg_addr_o = AW'(FREEZE);
      end else begin
        case (reg_cnt)
          3'd0: begin cfg_addr_o = AW'(FREEZE);      cfg_data_o = DW'(1);            end
          3'd1: begin cfg_addr_o = AW'(CORE_ID);     cfg_data_o = DW'(core_cnt);     end
          3'd2: begin cfg_addr_o = AW'(ICACHE_MODE); cfg_data_o = DW'(cache_mode_p); end
          3'd3: begin cfg_addr_o = AW'(DCACHE_MODE); cfg_data_o = DW'(cache_mode_p); end
          default: begin cfg_addr_o = AW'(CCE_MODE); cfg_data_o = DW'(cce_mode_p);   end
        endcase
      end
    end
  end

  assign busy_o = (state != S_IDLE) && (state != S_DONE);
  assign done_o = (state == S_DONE);

  bp_cfg_seq_gap_timer #(.gap_cycles_p(gap_cycles_p)) u_gap (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (gap_load),
    .en_i      (state == S_GAP),
    .expired_o (gap_expired)
  );

`ifdef BP_CFG_SEQ_READBACK_EN
  logic error;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      error <= 1'b0;
    else if (state == S_RWAIT && cfg_r_data_v_i && cfg_r_data_i != cfg_data_o)
      error <= 1'b1;
  end

  assign cfg_r_v_o = (state == S_READ);
  assign error_o   = error;
`endif

endmodule

// File: tb/tb_bp_cfg_seq.sv
// Directed bench for bp_cfg_seq: one instance with 1 core / no gap, one with 4 cores / gap 4.
module tb_bp_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start, ready, sel;

  logic        v_a, busy_a, done_a;
  logic [0:0]  core_a;
  logic [15:0] addr_a;
  logic [31:0] data_a;
  logic        v_b, busy_b, done_b;
  logic [1:0]  core_b;
  logic [15:0] addr_b;
  logic [31:0] data_b;

  bp_cfg_seq #(.num_core_p(1), .gap_cycles_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(rst_a), .start_i(start),
    .cfg_v_o(v_a), .cfg_ready_i(ready), .cfg_core_id_o(core_a),
    .cfg_addr_o(addr_a), .cfg_data_o(data_a), .busy_o(busy_a), .done_o(done_a)
  );

  bp_cfg_seq #(.num_core_p(4), .gap_cycles_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_b), .start_i(start),
    .cfg_v_o(v_b), .cfg_ready_i(ready), .cfg_core_id_o(core_b),
    .cfg_addr_o(addr_b), .cfg_data_o(data_b), .busy_o(busy_b), .done_o(done_b)
  );

  logic        m_v, m_busy, m_done;
  logic [31:0] m_core, m_addr, m_data;

  always_comb begin
    if (sel) begin
      m_v = v_b; m_busy = busy_b; m_done = done_b;
      m_core = 32'(core_b); m_addr = 32'(addr_b); m_data = data_b;
    end else begin
      m_v = v_a; m_busy = busy_a; m_done = done_a;
      m_core = 32'(core_a); m_addr = 32'(addr_a); m_data = data_a;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_core[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference write list for n cores: 5 programming writes per core, then one unfreeze per core.
  function automatic logic [31:0] exp_addr(input int n, input int k);
    if (k >= 5 * n) return 32'h2;
    case (k % 5)
      0: return 32'h2;
      1: return 32'h4;
      2: return 32'h6;
      3: return 32'h8;
      default: return 32'hA;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int n, input int k);
    if (k >= 5 * n) return 32'h0;
    if (k % 5 == 0) return 32'h1;
    if (k % 5 == 1) return 32'(k / 5);
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_core(input int n, input int k);
    return (k < 5 * n) ? 32'(k / 5) : 32'(k - 5 * n);
  endfunction

  // Called in the first PROG cycle; records accepted writes until done_o, checking stall stability.
  task automatic run_seq(input int budget, input int pct, output int done_cyc);
    logic pend;
    logic [31:0] h_addr, h_data, h_core;
    pend = 1'b0;
    h_addr = '0; h_data = '0; h_core = '0;
    done_cyc = -1;
    q_addr.delete(); q_data.delete(); q_core.delete();
    for (int c = 0; c < budget; c++) begin
      if (m_done) begin
        done_cyc = c;
        break;
      end
      ready = ($urandom_range(99) < pct);
      if (pend) begin
        chk("hold_v", 32'(m_v), 32'h1);
        chk("hold_addr", m_addr, h_addr);
        chk("hold_data", m_data, h_data);
        chk("hold_core", m_core, h_core);
      end
      if (m_v) begin
        if (ready) begin
          q_addr.push_back(m_addr);
          q_data.push_back(m_data);
          q_core.push_back(m_core);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          h_addr = m_addr; h_data = m_data; h_core = m_core;
        end
      end else begin
        pend = 1'b0;
      end
      tick();
    end
    chk("done_reached", 32'(m_done), 32'h1);
    ready = 1'b1;
  endtask

  task automatic check_writes(input int n);
    chk("n_writes", 32'(q_addr.size()), 32'(6 * n));
    for (int k = 0; k < q_addr.size() && k < 6 * n; k++) begin
      chk($sformatf("addr[%0d]", k), q_addr[k], exp_addr(n, k));
      chk($sformatf("data[%0d]", k), q_data[k], exp_data(n, k));
      chk($sformatf("core[%0d]", k), q_core[k], exp_core(n, k));
    end
  endtask

  initial begin
    int dc;
    int vcount;
    logic [31:0] a1_addr [6];
    logic [31:0] a1_data [6];
    a1_addr = '{32'h2, 32'h4, 32'h6, 32'h8, 32'hA, 32'h2};
    a1_data = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; start = 1'b0; ready = 1'b1;
    #2;
    chk("rst_a_v", 32'(m_v), 32'h0);
    chk("rst_a_busy", 32'(m_busy), 32'h0);
    chk("rst_a_done", 32'(m_done), 32'h0);
    sel = 1'b1;
    #1;
    chk("rst_b_v", 32'(m_v), 32'h0);
    chk("rst_b_addr", m_addr, 32'h0);
    chk("rst_b_data", m_data, 32'h0);
    sel = 1'b0;

    // 1 core, no gap, ready tied high
    tick(); rst_a = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(m_busy), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", 32'(m_busy), 32'h1);
    run_seq(100, 100, dc);
    chk("a_n_writes", 32'(q_addr.size()), 32'h6);
    for (int k = 0; k < 6 && k < q_addr.size(); k++) begin
      chk($sformatf("a_addr[%0d]", k), q_addr[k], a1_addr[k]);
      chk($sformatf("a_data[%0d]", k), q_data[k], a1_data[k]);
      chk($sformatf("a_core[%0d]", k), q_core[k], 32'h0);
    end
    chk("a_done_cycle", 32'(dc), 32'd6);
    chk("a_busy_done", 32'(m_busy), 32'h0);

    // 4 cores, gap 4, ready tied high
    rst_a = 1'b0; sel = 1'b1;
    tick(); rst_b = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    run_seq(1000, 100, dc);
    check_writes(4);
    chk("b_done_cycle", 32'(dc), 32'd116);

    // start held after DONE
    start = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_v) vcount++;
    end
    chk("no_write_after_done", 32'(vcount), 32'h0);
    chk("done_sticky", 32'(m_done), 32'h1);
    start = 1'b0;

    // 30% ready backpressure
    tick(); rst_b = 1'b0; tick(); rst_b = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    run_seq(3000, 30, dc);
    check_writes(4);

    // async reset during third write of core 2, then restart
    tick(); rst_b = 1'b0; tick(); rst_b = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (m_v && m_addr == 32'h6 && m_core == 32'h2) break;
      tick();
    end
    chk("found_core2_icache", m_addr, 32'h6);
    rst_b = 1'b0;
    #1;
    chk("async_rst_v", 32'(m_v), 32'h0);
    chk("async_rst_addr", m_addr, 32'h0);
    chk("async_rst_data", m_data, 32'h0);
    chk("async_rst_core", m_core, 32'h0);
    chk("async_rst_busy", 32'(m_busy), 32'h0);
    tick(); rst_b = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_v", 32'(m_v), 32'h1);
    chk("restart_addr", m_addr, 32'h2);
    chk("restart_data", m_data, 32'h1);
    chk("restart_core", m_core, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
